chip8_draw_sequencer: RTL
=========================

// Module: chip8_draw_sequencer
// PURPOSE
//  Multi-cycle sequencer for CHIP-8 DXYN (sprite draw) and 00E0 (clear) commands.
//  Fetches sprite bytes from program RAM one per row. Read-modify-writes one 64-bit
//  framebuffer row per sprite row. Reports the VF collision flag.
//  Shares the single framebuffer RAM port with video scan-out; scan-out always has priority.
//  Sits between the instruction core (command source) and the framebuffer/program RAMs.
// PARAMETERS
//  FB_COLS   64   pixels per row (framebuffer word width)
//  FB_ROWS   32   rows; row address width = $clog2(FB_ROWS)
//  ADDR_W    12   program RAM address width
//  MAX_N     15   max sprite rows per draw
// PORTS
//  clk        in   1       single clock; all logic on posedge
//  rst        in   1       synchronous, active-high reset
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       high only in IDLE; accept on cmd_valid&&cmd_ready
//  cmd_clear  in   1       1 = clear screen; x/y/n/i ignored
//  cmd_x      in   6       sprite X (VX[5:0])
//  cmd_y      in   5       sprite Y (VY[4:0])
//  cmd_n      in   4       sprite row count N
//  cmd_i      in   12      sprite base address I
//  done       out  1       one-cycle pulse when the command completes
//  vf         out  1       collision result; valid with done; held until next done
//  busy       out  1       ~cmd_ready
//  mem_rd_en  out  1       program RAM read strobe
//  mem_addr   out  12      program RAM address
//  mem_rdata  in   8       sprite byte; valid 1 cycle after mem_rd_en
//  fb_rd_en   out  1       framebuffer read strobe
//  fb_wr_en   out  1       framebuffer write strobe (never asserted with fb_rd_en)
//  fb_addr    out  5       framebuffer row address
//  fb_wdata   out  64      row write data; bit 63 = leftmost pixel
//  fb_rdata   in   64      row read data; valid 1 cycle after fb_rd_en
//  scan_req   in   1       scan-out wants a row this cycle (always granted)
//  scan_row   in   5       scan-out row address
//  scan_valid out  1       registered: fb_rdata is scan data (scan_req delayed 1 cycle)
// BEHAVIOUR
//  Reset: state=IDLE, cmd_ready=1, done=0, vf=0, busy=0; all RAM strobes 0; scan_valid=0.
//  Arbitration: if scan_req=1, fb_addr=scan_row, fb_rd_en=1, fb_wr_en=0. Engine fb access stalls that cycle.
//  FSM: IDLE -> (accept) ISSUE | CLEAR | DONE (draw with n=0).
//   ISSUE: wait while scan_req. Otherwise, in the same cycle, issue mem_rd_en with mem_addr=(I+k) mod 4096
//          and fb_rd_en with fb_addr=(y+k) mod 32. -> MERGE.
//   MERGE: mem_rdata and fb_rdata valid. Rotate sprite: {byte,56'b0} rotated right by x (wraps mod 64).
//          Register new=row^spr. Set hit |= |(row&spr). -> WRITE.
//   WRITE: wait while scan_req. Otherwise fb_wr_en, same row addr, fb_wdata=new. k++.
//          -> ISSUE if k<n, else DONE.
//   CLEAR: while scan_req=1, stall. Otherwise write 64'b0 to row r, r++. After row 31 -> DONE; hit=0.
//   DONE: done=1 for one cycle; vf<=hit. -> IDLE.
//  Latency with no scan traffic (accept = cycle 0):
//   draw: done in cycle 3n+1; n=0 gives done in cycle 1 with vf=0.
//   clear: done in cycle 33.
//  Each scan_req cycle that collides with ISSUE/WRITE/CLEAR adds exactly 1 cycle. MERGE never stalls.
//  Commands arriving while busy are not accepted; the source holds cmd_valid.
//  Command fields are latched at accept; input changes while busy are ignored.
//  Row wrap: a sprite at y=30 with n=4 writes rows 30,31,0,1. Address wrap: I=0xFFF, k=1 reads 0x000.
//  Collision is per pixel over all rows: vf=1 if any set sprite pixel hits a set framebuffer pixel.
//  rst mid-command: -> IDLE next cycle. No done pulse. No further writes.
//  Rows already written stay written; vf is cleared.
// STRUCTURE
//  chip8_pkg: FB_COLS/FB_ROWS/FONT constants, fb_row_t (logic [63:0]), draw_state_t enum.
//  Sub-module chip8_sprite_row_merge (combinational): x, sprite byte, row -> new row, hit.
//  Arbiter mux and FSM live in this module.
// TESTING
//  1. Draw x=0,y=0,n=5,I=0x050 (font "0": F0 90 90 90 F0) on blank fb
//     -> rows 0-4 = F0.../90... (top byte), done at cycle 16, vf=0.
//  2. Repeat test 1 -> rows 0-4 all zero, vf=1.
//  3. x=60,y=31,n=2, byte FF,FF -> row31=0xF00000000000000F; row0 same; vf=0 (X and Y wrap).
//  4. Clear after test 1 with scan_req high for 4 cycles mid-clear
//     -> all 32 rows 0, done at cycle 37, scan_valid follows scan_req by 1 cycle.
//  5. n=0 -> no RAM strobes, done cycle 1, vf=0. cmd_valid while busy -> no accept.
//  6. rst asserted in MERGE of row 2 of n=5 -> IDLE next cycle, no done, rows 0-1 written, rows 2-4 untouched.

Source files
------------

// File: rtl/chip8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chip8_pkg
// Description : Shared constants, types and helpers for the CHIP-8 draw
//               sequencer: framebuffer geometry, font location, the row
//               word type, the sequencer state enum and the sprite placement
//               (rotation) helper.
// Revision    : 1.0  initial release
// ============================================================================
package chip8_pkg;

    localparam int FB_COLS = 64;                    // pixels per row
    localparam int FB_ROWS = 32;                    // rows in the framebuffer
    localparam int ROW_W   = $clog2(FB_ROWS);       // row address width
    localparam int ADDR_W  = 12;                    // program RAM address width
    localparam int MAX_N   = 15;                    // max sprite rows per draw
    localparam int N_W     = $clog2(MAX_N + 1);     // sprite row count width

    // Built-in hex font: 16 glyphs of 5 bytes starting at this address.
    localparam logic [ADDR_W-1:0] FONT_BASE        = 12'h050;
    localparam int                FONT_GLYPH_BYTES = 5;

    typedef logic [FB_COLS-1:0] fb_row_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_CLEAR = 3'd4,
        ST_DONE  = 3'd5
    } draw_state_t;

    // Place an 8-pixel sprite byte at column x of a 64-pixel row. Bit 63 is
    // the leftmost pixel, so the byte starts in the top bits and is rotated
    // right; pixels pushed past column 63 wrap around to column 0.
    function automatic fb_row_t place_sprite(input logic [7:0] sprite_byte,
                                             input logic [5:0] x);
        fb_row_t base;
        base = {sprite_byte, 56'b0};
        return (base >> x) | (base << (7'd64 - {1'b0, x}));
    endfunction

endpackage : chip8_pkg
`default_nettype wire

// File: rtl/chip8_sprite_row_merge.sv
`default_nettype none
// ============================================================================
// Module      : chip8_sprite_row_merge
// Description : Combinational XOR-merge of one sprite byte into one
//               framebuffer row, with collision detection.
//   x            in   6   horizontal sprite position (wraps mod 64)
//   sprite_byte  in   8   sprite row pattern, bit 7 = leftmost pixel
//   row          in   64  current framebuffer row, bit 63 = leftmost pixel
//   new_row      out  64  row with the sprite XORed in
//   hit          out  1   a set sprite pixel landed on a set row pixel
// Revision    : 1.0  initial release
// ============================================================================
module chip8_sprite_row_merge
    import chip8_pkg::*;
(
    input  logic [5:0]  x,
    input  logic [7:0]  sprite_byte,
    input  fb_row_t     row,
    output fb_row_t     new_row,
    output logic        hit
);

    fb_row_t spr;

    always_comb begin
        spr     = place_sprite(sprite_byte, x);
        new_row = row ^ spr;
        hit     = |(row & spr);
    end

endmodule : chip8_sprite_row_merge
`default_nettype wire

// File: rtl/chip8_draw_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : chip8_draw_sequencer
// Description : Multi-cycle engine for CHIP-8 DXYN (sprite draw) and 00E0
//               (clear). One sprite byte is fetched per row and the matching
//               framebuffer row is read, XOR-merged and written back. The
//               single framebuffer port is shared with video scan-out, which
//               always wins; the engine simply stalls on a conflict.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake (ready only when idle)
//   cmd_clear,x,y,n,i           command fields, latched at accept
//   done, vf, busy              completion pulse, collision flag, busy
//   mem_rd_en/addr/rdata        program RAM read port (1-cycle latency)
//   fb_rd_en/wr_en/addr/wdata/rdata  framebuffer port (1-cycle read latency)
//   scan_req/scan_row/scan_valid     scan-out request and data-valid tag
// Revision    : 1.0  initial release
// ============================================================================
module chip8_draw_sequencer
    import chip8_pkg::*;
(
    input  logic                clk,
    input  logic                rst,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_clear,
    input  logic [5:0]          cmd_x,
    input  logic [ROW_W-1:0]    cmd_y,
    input  logic [N_W-1:0]      cmd_n,
    input  logic [ADDR_W-1:0]   cmd_i,

    output logic                done,
    output logic                vf,
    output logic                busy,

    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [7:0]          mem_rdata,

    output logic                fb_rd_en,
    output logic                fb_wr_en,
    output logic [ROW_W-1:0]    fb_addr,
    output fb_row_t             fb_wdata,
    input  fb_row_t             fb_rdata,

    input  logic                scan_req,
    input  logic [ROW_W-1:0]    scan_row,
    output logic                scan_valid
);

    draw_state_t        state;
    draw_state_t        next_state;

    // Latched command fields.
    logic [5:0]         x_r;
    logic [ROW_W-1:0]   y_r;
    logic [N_W-1:0]     n_r;
    logic [ADDR_W-1:0]  i_r;

    logic [N_W-1:0]     k_r;          // sprite row being processed
    logic [ROW_W-1:0]   clr_row_r;    // row being cleared
    logic               hit_r;        // accumulated collision
    logic               vf_r;
    logic               scan_valid_r;
    fb_row_t            new_row_r;    // merged row awaiting write-back

    // Engine-side framebuffer request, before scan-out arbitration.
    logic               eng_fb_rd;
    logic               eng_fb_wr;
    logic [ROW_W-1:0]   eng_addr;
    logic               accept;

    fb_row_t            merge_row;
    logic               merge_hit;

    // In MERGE the RAM outputs hold the byte and row requested in ISSUE.
    chip8_sprite_row_merge u_merge (
        .x           (x_r),
        .sprite_byte (mem_rdata),
        .row         (fb_rdata),
        .new_row     (merge_row),
        .hit         (merge_hit)
    );

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        done       = 1'b0;
        mem_rd_en  = 1'b0;
        eng_fb_rd  = 1'b0;
        eng_fb_wr  = 1'b0;
        eng_addr   = y_r + {1'b0, k_r};
        accept     = 1'b0;

        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_clear)
                        next_state = ST_CLEAR;
                    else if (cmd_n == '0)
                        next_state = ST_DONE;
                    else
                        next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Sprite fetch and row read go out together so both land in MERGE.
                if (!scan_req) begin
                    mem_rd_en  = 1'b1;
                    eng_fb_rd  = 1'b1;
                    next_state = ST_MERGE;
                end
            end
            ST_MERGE: begin
                next_state = ST_WRITE;
            end
            ST_WRITE: begin
                if (!scan_req) begin
                    eng_fb_wr = 1'b1;
                    if (({1'b0, k_r} + 5'd1) < {1'b0, n_r})
                        next_state = ST_ISSUE;
                    else
                        next_state = ST_DONE;
                end
            end
            ST_CLEAR: begin
                eng_addr = clr_row_r;
                if (!scan_req) begin
                    eng_fb_wr = 1'b1;
                    if (clr_row_r == ROW_W'(FB_ROWS - 1))
                        next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        // A reset arriving mid-command must not leak a write, fetch or pulse
        // in the cycle it is sampled.
        if (rst) begin
            mem_rd_en = 1'b0;
            eng_fb_wr = 1'b0;
            done      = 1'b0;
        end
    end

    // Scan-out owns the port whenever it asks; engine requests were already
    // suppressed in that case, so rd/wr can never be high together.
    assign fb_rd_en   = scan_req | eng_fb_rd;
    assign fb_wr_en   = eng_fb_wr;
    assign fb_addr    = scan_req ? scan_row : eng_addr;
    assign fb_wdata   = (state == ST_CLEAR) ? '0 : new_row_r;
    assign mem_addr   = i_r + {{(ADDR_W-N_W){1'b0}}, k_r};
    assign busy       = ~cmd_ready;
    assign vf         = vf_r;
    assign scan_valid = scan_valid_r;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            x_r          <= '0;
            y_r          <= '0;
            n_r          <= '0;
            i_r          <= '0;
            k_r          <= '0;
            clr_row_r    <= '0;
            hit_r        <= 1'b0;
            vf_r         <= 1'b0;
            scan_valid_r <= 1'b0;
            new_row_r    <= '0;
        end else begin
            state        <= next_state;
            scan_valid_r <= scan_req;

            if (accept) begin
                x_r       <= cmd_x;
                y_r       <= cmd_y;
                n_r       <= cmd_n;
                i_r       <= cmd_i;
                k_r       <= '0;
                clr_row_r <= '0;
                hit_r     <= 1'b0;
            end

            if (state == ST_MERGE) begin
                new_row_r <= merge_row;
                hit_r     <= hit_r | merge_hit;
            end

            if (eng_fb_wr && state == ST_WRITE)
                k_r <= k_r + 1'b1;

            if (eng_fb_wr && state == ST_CLEAR)
                clr_row_r <= clr_row_r + 1'b1;

            // vf is published as DONE is entered so it is valid alongside
            // the done pulse. Clears and empty draws report no collision.
            if (next_state == ST_DONE && state != ST_DONE)
                vf_r <= (state == ST_WRITE) ? (hit_r | 1'b0) : 1'b0;
        end
    end

endmodule : chip8_draw_sequencer
`default_nettype wire
